// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit scheduler state encoding.
package uart_pkg;

  localparam int DBIT_DEF   = 8;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4,
    FLUSH     = 3'd5
  } tx_sched_state_t;

endpackage

// File: rtl/uart_tx_sched_gap_counter.sv
// Tick-enabled up-counter with synchronous clear; flags the tick that completes LIMIT counts.
module gap_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_tc
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)       r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_tick) r_cnt <= r_cnt + W'(1);
  end

  assign o_tc = i_tick && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/uart_tx_sched.sv
// Pops bytes from the TX FIFO and hands them to the UART transmitter, with an
// s_tick-timed idle gap after each frame and a drain-only flush mode.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DBIT      = DBIT_DEF,
  parameter int GAP_TICKS = OVERSAMPLE,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_s_tick,
  input  logic             i_fifo_empty,
  input  logic [DBIT-1:0]  i_fifo_rdata,
  output logic             o_fifo_rd,
  output logic             o_tx_start,
  output logic [DBIT-1:0]  o_tx_data,
  input  logic             i_tx_done_tick,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frames_sent
);

  tx_sched_state_t r_state, w_state_nxt;
  logic [DBIT-1:0]  r_tx_data;
  logic [CNT_W-1:0] r_frames_sent;
  logic             w_load, w_done, w_gap_tc;

  // Counter needs a nonzero limit even when the gap is disabled; it is then never ticked.
  gap_counter #(.LIMIT((GAP_TICKS > 0) ? GAP_TICKS : 1)) u_gap (
    .clk    (clk),
    .Reset  (Reset),
    .i_clr  (w_done),
    .i_tick (i_s_tick && (r_state == GAP)),
    .o_tc   (w_gap_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_flush && !i_fifo_empty) begin
          w_state_nxt = FLUSH;
        end else if (i_en && !i_fifo_empty) begin
          w_state_nxt = POP;
          w_load      = 1'b1;
        end
      end
      POP:   w_state_nxt = START;
      START: w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_done_tick) begin
          w_done      = 1'b1;
          w_state_nxt = (GAP_TICKS > 0) ? GAP : IDLE;
        end
      end
      GAP:     if (w_gap_tc) w_state_nxt = IDLE;
      FLUSH:   if (i_fifo_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_tx_data     <= '0;
      r_frames_sent <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_tx_data <= i_fifo_rdata;
      if (w_done) r_frames_sent <= r_frames_sent + CNT_W'(1);
    end
  end

  // Flush pops are gated by empty so the FIFO can never underflow.
  assign o_fifo_rd     = (r_state == POP) || ((r_state == FLUSH) && !i_fifo_empty);
  assign o_tx_start    = (r_state == START);
  assign o_busy        = (r_state != IDLE);
  assign o_tx_data     = r_tx_data;
  assign o_frames_sent = r_frames_sent;

endmodule
